fwd_scoreboard: RTL and testbench

- Parametrised forwarding and stall unit for the pipelined MIPS core.
- Replaces the fixed 2-bit forward-select muxes with a tracked write-tag pipeline.
- Sits beside the decode stage. Tracks in-flight register writes over NUM_STAGES downstream stages and resolves NUM_RPORTS operand reads per cycle.
- Outputs the forward select, the forwarded data, a pending flag per port, and one global stall.

---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_scoreboard_if.sv | 59 +++++
 rtl/fwd_port_lookup.sv | 71 +++++++
 rtl/fwd_scoreboard.sv | 134 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// ----------------------------------------------------------------------------
// fwd_pkg : shared types, default widths and helpers for fwd_scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fwd_pkg;

  localparam int DEF_NUM_STAGES = 3;
  localparam int DEF_NUM_RPORTS = 2;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TN_W       = 2;

  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] waddr;
    logic [DEF_TN_W-1:0]   tnew;
  } fwd_entry_t;

  // One code per stage plus the register-file code.
  function automatic int sel_width(input int num_stages);
    return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_scoreboard_if.sv
// ----------------------------------------------------------------------------
// fwd_scoreboard_if : decode-side bus of the forwarding unit. Option: FWD_SCOREBOARD_STATS_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fwd_scoreboard_if #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_RPORTS = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int TN_W       = 2
);
  import fwd_pkg::*;
  localparam int SEL_W = sel_width(NUM_STAGES);

  logic                           freeze;
  logic                           flush;
  logic                           issue_valid;
  logic [ADDR_W-1:0]              issue_waddr;
  logic [TN_W-1:0]                issue_tnew;
  logic [NUM_RPORTS*ADDR_W-1:0]   rd_addr;
  logic [NUM_RPORTS*TN_W-1:0]     rd_tuse;
  logic [NUM_RPORTS*DATA_W-1:0]   rf_rdata;
  logic [NUM_STAGES*DATA_W-1:0]   stage_wdata;
  logic                           stall;
  logic [NUM_RPORTS*SEL_W-1:0]    fwd_sel;
  logic [NUM_RPORTS*DATA_W-1:0]   fwd_data;
  logic [NUM_RPORTS-1:0]          fwd_pend;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0]                    stat_stall_cnt;
  logic [31:0]                    stat_fwd_cnt;

  modport master (
    output freeze, flush, issue_valid, issue_waddr, issue_tnew,
           rd_addr, rd_tuse, rf_rdata, stage_wdata,
    input  stall, fwd_sel, fwd_data, fwd_pend, stat_stall_cnt, stat_fwd_cnt
  );
  modport slave (
    input  freeze, flush, issue_valid, issue_waddr, issue_tnew,
           rd_addr, rd_tuse, rf_rdata, stage_wdata,
    output stall, fwd_sel, fwd_data, fwd_pend, stat_stall_cnt, stat_fwd_cnt
  );
`else
  modport master (
    output freeze, flush, issue_valid, issue_waddr, issue_tnew,
           rd_addr, rd_tuse, rf_rdata, stage_wdata,
    input  stall, fwd_sel, fwd_data, fwd_pend
  );
  modport slave (
    input  freeze, flush, issue_valid, issue_waddr, issue_tnew,
           rd_addr, rd_tuse, rf_rdata, stage_wdata,
    output stall, fwd_sel, fwd_data, fwd_pend
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fwd_port_lookup.sv
// ----------------------------------------------------------------------------
// fwd_port_lookup : youngest-match search and operand select for one read port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fwd_port_lookup
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int TN_W       = 2,
  parameter int SEL_W      = sel_width(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0]             valid_i,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0] waddr_i,
  input  logic [NUM_STAGES-1:0][TN_W-1:0]   tnew_i,
  input  logic [ADDR_W-1:0]                 rd_addr_i,
  input  logic [TN_W-1:0]                   rd_tuse_i,
  input  logic [DATA_W-1:0]                 rf_rdata_i,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0] stage_wdata_i,
  output logic [SEL_W-1:0]                  sel_o,
  output logic [DATA_W-1:0]                 data_o,
  output logic                              pend_o,
  output logic                              stall_o
);

  logic              w_hit;
  logic [TN_W-1:0]   w_hit_tnew;
  logic [SEL_W-1:0]  w_hit_sel;
  logic [DATA_W-1:0] w_hit_data;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_tnew = '0;
    w_hit_sel  = SEL_W'(SEL_RF);
    w_hit_data = rf_rdata_i;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (valid_i[k] && (waddr_i[k] == rd_addr_i)) begin
        w_hit      = 1'b1;
        w_hit_tnew = tnew_i[k];
        w_hit_sel  = SEL_W'(k + 1);
        w_hit_data = stage_wdata_i[k];
      end
    end
    if (rd_addr_i == '0) begin
      w_hit = 1'b0;
    end
  end

  always_comb begin
    sel_o   = SEL_W'(SEL_RF);
    data_o  = rf_rdata_i;
    pend_o  = 1'b0;
    stall_o = 1'b0;
    if (w_hit) begin
      if (w_hit_tnew == '0) begin
        sel_o  = w_hit_sel;
        data_o = w_hit_data;
      end else if (w_hit_tnew > rd_tuse_i) begin
        stall_o = 1'b1;
      end else begin
        pend_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ----------------------------------------------------------------------------
// fwd_scoreboard : write-tag pipeline, per-port forwarding and global stall. Option: FWD_SCOREBOARD_STATS_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int NUM_RPORTS = DEF_NUM_RPORTS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TN_W       = DEF_TN_W
) (
  input  logic            clk,
  input  logic            reset_n,
  fwd_scoreboard_if.slave bus
);

  localparam int SEL_W = sel_width(NUM_STAGES);

  logic [NUM_STAGES-1:0]             valid_q, valid_d;
  logic [NUM_STAGES-1:0][ADDR_W-1:0] waddr_q, waddr_d;
  logic [NUM_STAGES-1:0][TN_W-1:0]   tnew_q, tnew_d;

  logic [NUM_STAGES-1:0]             w_valid;
  logic [NUM_RPORTS-1:0][SEL_W-1:0]  w_sel;
  logic [NUM_RPORTS-1:0][DATA_W-1:0] w_data;
  logic [NUM_RPORTS-1:0]             w_pend;
  logic [NUM_RPORTS-1:0]             w_stall_req;
  logic                              w_stall;
  logic                              w_issue_ok;

  // Masking by reset_n keeps outputs at their idle values while reset is held.
  assign w_valid    = valid_q & {NUM_STAGES{reset_n}};
  assign w_stall    = |w_stall_req;
  assign w_issue_ok = bus.issue_valid && (bus.issue_waddr != '0) && !w_stall && !bus.flush;

  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    tnew_d  = tnew_q;
    if (!bus.freeze) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        waddr_d[k] = waddr_q[k-1];
        tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TN_W'(1);
      end
      valid_d[0] = w_issue_ok;
      waddr_d[0] = bus.issue_waddr;
      tnew_d[0]  = bus.issue_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      waddr_q <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      tnew_q  <= tnew_d;
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    fwd_port_lookup #(
      .NUM_STAGES (NUM_STAGES),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .TN_W       (TN_W),
      .SEL_W      (SEL_W)
    ) u_lookup (
      .valid_i       (w_valid),
      .waddr_i       (waddr_q),
      .tnew_i        (tnew_q),
      .rd_addr_i     (bus.rd_addr[p*ADDR_W +: ADDR_W]),
      .rd_tuse_i     (bus.rd_tuse[p*TN_W +: TN_W]),
      .rf_rdata_i    (bus.rf_rdata[p*DATA_W +: DATA_W]),
      .stage_wdata_i (bus.stage_wdata),
      .sel_o         (w_sel[p]),
      .data_o        (w_data[p]),
      .pend_o        (w_pend[p]),
      .stall_o       (w_stall_req[p])
    );
  end

  assign bus.stall    = w_stall;
  assign bus.fwd_sel  = w_sel;
  assign bus.fwd_data = w_data;
  assign bus.fwd_pend = w_pend;

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;
  logic [32:0] w_fwd_ports;
  logic [32:0] w_fwd_sum;

  always_comb begin
    w_fwd_ports = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      if (w_sel[p] != '0) begin
        w_fwd_ports = w_fwd_ports + 33'd1;
      end
    end
  end

  assign w_fwd_sum = {1'b0, fwd_cnt_q} + w_fwd_ports;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!bus.freeze) begin
      if (w_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      fwd_cnt_q <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
    end
  end

  assign bus.stat_stall_cnt = stall_cnt_q;
  assign bus.stat_fwd_cnt   = fwd_cnt_q;
`endif

  // A producer must finish before it leaves the last tracked stage.
  a_tnew_range : assert property (@(posedge clk) disable iff (!reset_n)
    bus.issue_valid |-> (bus.issue_tnew <= TN_W'(NUM_STAGES - 1)));

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_fwd_scoreboard : directed plus random stimulus against an age-based reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int NS = 3;
  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int SW = sel_width(NS);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NUM_STAGES(NS), .NUM_RPORTS(NR), .ADDR_W(AW), .DATA_W(DW), .TN_W(TW)) bus();

  fwd_scoreboard #(.NUM_STAGES(NS), .NUM_RPORTS(NR), .ADDR_W(AW), .DATA_W(DW), .TN_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Each in-flight producer is tracked by its age in cycles since issue.
  typedef struct {
    int addr;
    int t;
    int age;
  } inflight_t;

  typedef struct packed {
    bit             stall;
    bit [NR*SW-1:0] sel;
    bit [NR*DW-1:0] data;
    bit [NR-1:0]    pend;
  } exp_t;

  inflight_t fl_q[$];
  exp_t      exp_q[$];
  bit        last_stall = 1'b0;
  int        n_cmp = 0;
  int        n_err = 0;
  int        pool[6] = '{0, 1, 2, 3, 8, 9};

  task automatic model_edge();
    inflight_t nq[$];
    inflight_t r;
    if (!reset_n) begin
      fl_q.delete();
    end else if (!bus.freeze) begin
      foreach (fl_q[i]) begin
        r = fl_q[i];
        r.age = r.age + 1;
        if (r.age < NS) nq.push_back(r);
      end
      if (bus.issue_valid && (bus.issue_waddr != 0) && !last_stall && !bus.flush) begin
        r.addr = int'(bus.issue_waddr);
        r.t    = int'(bus.issue_tnew);
        r.age  = 0;
        nq.push_back(r);
      end
      fl_q = nq;
    end
  endtask

  task automatic predict();
    exp_t e;
    int   a, tuse, best_age, best_t, rem;
    e = '0;
    for (int p = 0; p < NR; p++) begin
      a        = int'(bus.rd_addr[p*AW +: AW]);
      tuse     = int'(bus.rd_tuse[p*TW +: TW]);
      best_age = NS;
      best_t   = 0;
      e.data[p*DW +: DW] = bus.rf_rdata[p*DW +: DW];
      foreach (fl_q[i]) begin
        if (reset_n && a != 0 && fl_q[i].addr == a && fl_q[i].age < best_age) begin
          best_age = fl_q[i].age;
          best_t   = fl_q[i].t;
        end
      end
      if (best_age < NS) begin
        rem = (best_t > best_age) ? best_t - best_age : 0;
        if (rem == 0) begin
          e.sel[p*SW +: SW]  = SW'(best_age + 1);
          e.data[p*DW +: DW] = bus.stage_wdata[best_age*DW +: DW];
        end else if (rem > tuse) begin
          e.stall = 1'b1;
        end else begin
          e.pend[p] = 1'b1;
        end
      end
    end
    last_stall = e.stall;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rn, input logic frz, input logic fl, input logic iv,
                      input int wa, input int tn, input int ra0, input int tu0,
                      input int ra1, input int tu1);
    @(posedge clk);
    model_edge();
    #1;
    reset_n         = rn;
    bus.freeze      = frz;
    bus.flush       = fl;
    bus.issue_valid = iv;
    bus.issue_waddr = AW'(wa);
    bus.issue_tnew  = TW'(tn);
    bus.rd_addr     = {AW'(ra1), AW'(ra0)};
    bus.rd_tuse     = {TW'(tu1), TW'(tu0)};
    bus.rf_rdata    = {$urandom, $urandom};
    bus.stage_wdata = {$urandom, 32'hDEADBEEF, $urandom};
    predict();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", 64'(bus.stall), 64'(e.stall));
        for (int p = 0; p < NR; p++) begin
          chk($sformatf("fwd_sel%0d", p),  64'(bus.fwd_sel[p*SW +: SW]),  64'(e.sel[p*SW +: SW]));
          chk($sformatf("fwd_data%0d", p), 64'(bus.fwd_data[p*DW +: DW]), 64'(e.data[p*DW +: DW]));
          chk($sformatf("fwd_pend%0d", p), 64'(bus.fwd_pend[p]),          64'(e.pend[p]));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : driver
    int wa, ra0, ra1;
    reset_n         = 1'b0;
    bus.freeze      = 1'b0;
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_waddr = AW'(8);
    bus.issue_tnew  = '0;
    bus.rd_addr     = {AW'(0), AW'(8)};
    bus.rd_tuse     = '0;
    bus.rf_rdata    = '0;
    bus.stage_wdata = '0;

    // Reset held with a pending issue and a matching read
    step(0, 0, 0, 1, 8, 0, 8, 0, 0, 0);
    step(0, 0, 0, 1, 8, 0, 8, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 8, 0, 0, 0);
    // ALU dependence
    step(1, 0, 0, 1, 8, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 8, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 8, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use
    step(1, 0, 0, 1, 9, 2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 9, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 9, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Youngest match wins
    step(1, 0, 0, 1, 8, 2, 0, 0, 0, 0);
    step(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 8, 0, 5, 0);
    // Writes to $0 are never tracked
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Freeze holds state, then flush bubbles entry 0
    step(1, 0, 0, 1, 3, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 7, 0, 4, 0, 3, 3);
    step(1, 1, 0, 1, 7, 0, 4, 0, 3, 0);
    step(1, 1, 1, 1, 7, 0, 4, 0, 3, 3);
    step(1, 0, 1, 1, 7, 0, 4, 0, 3, 3);
    step(1, 0, 0, 0, 0, 0, 7, 0, 4, 0);

    for (int i = 0; i < 400; i++) begin
      wa  = pool[$urandom_range(0, 5)];
      ra0 = pool[$urandom_range(0, 5)];
      ra1 = pool[$urandom_range(0, 5)];
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 70),
           wa, $urandom_range(0, NS - 1),
           ra0, $urandom_range(0, 3),
           ra1, $urandom_range(0, 3));
    end

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
